// File: rtl/rv32_pkg.sv
// Shared types and constants for the rv32 program loader.
//   rv32_data_t      : 32-bit data word as used on the core memory ports.
//   LD_CMD_*         : command byte codes of the loader stream.
//   rv32_ld_state_t  : loader FSM state encoding. The CSUM state only exists
//                      when PROG_CHECKSUM_EN is defined.
package rv32_pkg;

  typedef logic [31:0] rv32_data_t;

  localparam logic [7:0] LD_CMD_CLR  = 8'h00;
  localparam logic [7:0] LD_CMD_IMEM = 8'h01;
  localparam logic [7:0] LD_CMD_DMEM = 8'h02;
  localparam logic [7:0] LD_CMD_RUN  = 8'h03;
  localparam logic [7:0] LD_CMD_HALT = 8'h04;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_ADDR0,
    LD_ADDR1,
    LD_CNT0,
    LD_CNT1,
    LD_DATA,
    LD_WRITE
`ifdef PROG_CHECKSUM_EN
    , LD_CSUM
`endif
  } rv32_ld_state_t;

endpackage

// File: rtl/rv32_prog_loader_if.sv
// Byte-stream handshake bundle feeding the program loader.
//   ld_byte  : stream byte (source -> loader)
//   ld_valid : byte valid  (source -> loader)
//   ld_ready : loader can accept this cycle (loader -> source)
// Modports: master = byte source, slave = loader side.
interface rv32_prog_loader_if;
  logic [7:0] ld_byte;
  logic       ld_valid;
  logic       ld_ready;

  modport master (output ld_byte, output ld_valid, input  ld_ready);
  modport slave  (input  ld_byte, input  ld_valid, output ld_ready);
endinterface

// File: rtl/rv32_word_assembler.sv
// Collects four stream bytes into a little-endian 32-bit word.
//   clk, rst_n : clock, async active-low reset
//   clr        : drop any partial word (held while the loader is idle)
//   in_valid   : in_byte is consumed this cycle
//   in_byte    : incoming data byte
//   word       : assembled word, valid in the cycle word_done is high
//   word_done  : 4th byte of a word is being consumed this cycle
module rv32_word_assembler
  import rv32_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       in_valid,
  input  logic [7:0] in_byte,
  output rv32_data_t word,
  output logic       word_done
);

  // Only the first three bytes need storage; the fourth is combined
  // straight from the input so the word is ready on its accept cycle.
  logic [23:0] sr;
  logic [1:0]  cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr  <= '0;
      cnt <= '0;
    end else if (clr) begin
      sr  <= '0;
      cnt <= '0;
    end else if (in_valid) begin
      sr  <= {in_byte, sr[23:8]};
      cnt <= cnt + 2'd1;
    end
  end

  assign word      = {in_byte, sr};
  assign word_done = in_valid && (cnt == 2'd3);

endmodule

// File: rtl/rv32_prog_loader.sv
// Byte-stream program loader for rv32_core.
// Parses framed packets (CMD, then for IMEM/DMEM: ADDR lo/hi, CNT lo/hi,
// CNT little-endian words), writes words to the imem/dmem programming
// ports and controls the core reset.
//   rv32_io_clk, rv32_io_rst_n   : clock, async active-low reset
//   ld_byte/ld_valid/ld_ready    : byte stream handshake
//   rv32_io_imem_addr/data/w_en  : imem write port (1-cycle strobe)
//   rv32_io_dmem_addr/data/w_en  : dmem write port (1-cycle strobe)
//   rv32_io_program              : steers core dmem mux to loader ports
//   core_rst_n                   : core reset, 0 holds the core
//   ld_busy                      : packet in progress
//   ld_err                       : sticky error, cleared by CLR
// Optional feature macro PROG_CHECKSUM_EN: IMEM/DMEM packets end with an
// XOR checksum byte; a nonzero XOR over the whole packet sets ld_err.
module rv32_prog_loader
  import rv32_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              rv32_io_clk,
  input  logic              rv32_io_rst_n,
  input  logic [7:0]        ld_byte,
  input  logic              ld_valid,
  output logic              ld_ready,
  output logic [ADDR_W-1:0] rv32_io_imem_addr,
  output rv32_data_t        rv32_io_imem_data,
  output logic              rv32_io_imem_w_en,
  output logic [ADDR_W-1:0] rv32_io_dmem_addr,
  output rv32_data_t        rv32_io_dmem_data,
  output logic              rv32_io_dmem_w_en,
  output logic              rv32_io_program,
  output logic              core_rst_n,
  output logic              ld_busy,
  output logic              ld_err
);

`ifdef PROG_CHECKSUM_EN
  localparam rv32_ld_state_t LD_DONE = LD_CSUM;
`else
  localparam rv32_ld_state_t LD_DONE = LD_IDLE;
`endif

  rv32_ld_state_t    state;
  logic [ADDR_W-1:0] ptr;        // next write address
  logic [15:0]       words_left; // words still to write, incl. current
  logic [7:0]        lo_byte;    // low byte of ADDR / CNT while the high byte arrives
  logic              is_dmem;
  logic              acc;
  rv32_data_t        asm_word;
  logic              word_done;

  assign acc      = ld_valid && ld_ready;
  assign ld_ready = (state != LD_WRITE);
  assign ld_busy  = (state != LD_IDLE);

  rv32_word_assembler u_asm (
    .clk       (rv32_io_clk),
    .rst_n     (rv32_io_rst_n),
    .clr       (state == LD_IDLE),
    .in_valid  (acc && (state == LD_DATA)),
    .in_byte   (ld_byte),
    .word      (asm_word),
    .word_done (word_done)
  );

`ifdef PROG_CHECKSUM_EN
  // Running XOR of the packet; restarts on the command byte.
  logic [7:0] csum;
  always_ff @(posedge rv32_io_clk or negedge rv32_io_rst_n) begin
    if (!rv32_io_rst_n)  csum <= '0;
    else if (acc)        csum <= (state == LD_IDLE) ? ld_byte : (csum ^ ld_byte);
  end
`endif

  always_ff @(posedge rv32_io_clk or negedge rv32_io_rst_n) begin
    if (!rv32_io_rst_n) begin
      state             <= LD_IDLE;
      ptr               <= '0;
      words_left        <= '0;
      lo_byte           <= '0;
      is_dmem           <= 1'b0;
      rv32_io_imem_addr <= '0;
      rv32_io_imem_data <= '0;
      rv32_io_imem_w_en <= 1'b0;
      rv32_io_dmem_addr <= '0;
      rv32_io_dmem_data <= '0;
      rv32_io_dmem_w_en <= 1'b0;
      rv32_io_program   <= 1'b0;
      core_rst_n        <= 1'b0;
      ld_err            <= 1'b0;
    end else begin
      rv32_io_imem_w_en <= 1'b0;
      rv32_io_dmem_w_en <= 1'b0;
      case (state)
        LD_IDLE: if (acc) begin
          case (ld_byte)
            LD_CMD_IMEM, LD_CMD_DMEM: begin
              state           <= LD_ADDR0;
              core_rst_n      <= 1'b0;
              is_dmem         <= (ld_byte == LD_CMD_DMEM);
              rv32_io_program <= (ld_byte == LD_CMD_DMEM);
            end
            LD_CMD_RUN:  core_rst_n <= 1'b1;
            LD_CMD_HALT: core_rst_n <= 1'b0;
            LD_CMD_CLR:  ld_err     <= 1'b0;
            default:     ld_err     <= 1'b1;
          endcase
        end
        LD_ADDR0: if (acc) begin
          lo_byte <= ld_byte;
          state   <= LD_ADDR1;
        end
        // Address bits above ADDR_W are dropped here.
        LD_ADDR1: if (acc) begin
          ptr   <= ADDR_W'({ld_byte, lo_byte});
          state <= LD_CNT0;
        end
        LD_CNT0: if (acc) begin
          lo_byte <= ld_byte;
          state   <= LD_CNT1;
        end
        LD_CNT1: if (acc) begin
          words_left <= {ld_byte, lo_byte};
          if ({ld_byte, lo_byte} == 16'h0000) begin
            rv32_io_program <= 1'b0;
            state           <= LD_DONE;
          end else begin
            state <= LD_DATA;
          end
        end
        // Address/data are registered together with the strobe, so the
        // WRITE cycle presents a complete, stable write.
        LD_DATA: if (acc && word_done) begin
          if (is_dmem) begin
            rv32_io_dmem_addr <= ptr;
            rv32_io_dmem_data <= asm_word;
            rv32_io_dmem_w_en <= 1'b1;
          end else begin
            rv32_io_imem_addr <= ptr;
            rv32_io_imem_data <= asm_word;
            rv32_io_imem_w_en <= 1'b1;
          end
          state <= LD_WRITE;
        end
        LD_WRITE: begin
          ptr        <= ptr + ADDR_W'(1);
          words_left <= words_left - 16'd1;
          if (words_left == 16'd1) begin
            rv32_io_program <= 1'b0;
            state           <= LD_DONE;
          end else begin
            state <= LD_DATA;
          end
        end
`ifdef PROG_CHECKSUM_EN
        LD_CSUM: if (acc) begin
          if ((csum ^ ld_byte) != 8'h00) ld_err <= 1'b1;
          state <= LD_IDLE;
        end
`endif
        default: state <= LD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_prog_loader.sv
module tb_rv32_prog_loader;
  import rv32_pkg::*;

  localparam int ADDR_W = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rv32_prog_loader_if lif ();

  logic [ADDR_W-1:0] imem_addr, dmem_addr;
  logic [31:0]       imem_data, dmem_data;
  logic              imem_w_en, dmem_w_en, prog_o, core_rst_n, ld_busy, ld_err;

  rv32_prog_loader #(.ADDR_W(ADDR_W)) dut (
    .rv32_io_clk       (clk),
    .rv32_io_rst_n     (rst_n),
    .ld_byte           (lif.ld_byte),
    .ld_valid          (lif.ld_valid),
    .ld_ready          (lif.ld_ready),
    .rv32_io_imem_addr (imem_addr),
    .rv32_io_imem_data (imem_data),
    .rv32_io_imem_w_en (imem_w_en),
    .rv32_io_dmem_addr (dmem_addr),
    .rv32_io_dmem_data (dmem_data),
    .rv32_io_dmem_w_en (dmem_w_en),
    .rv32_io_program   (prog_o),
    .core_rst_n        (core_rst_n),
    .ld_busy           (ld_busy),
    .ld_err            (ld_err)
  );

  int checks = 0;
  int errors = 0;
  int prog_bad = 0;
  int rdy_low = 0;
  bit gaps = 0;
  logic [ADDR_W+31:0] got_i[$], got_d[$], exp_i[$], exp_d[$];
  logic [7:0] pkt[$];

  // Write monitor: one entry per strobe cycle, so a stretched strobe shows
  // up as an extra write.
  always @(negedge clk) begin
    if (imem_w_en) got_i.push_back({imem_addr, imem_data});
    if (dmem_w_en) begin
      got_d.push_back({dmem_addr, dmem_data});
      if (!prog_o) prog_bad++;
    end
    if (rst_n && !lif.ld_ready) rdy_low++;
  end

  task automatic send_byte(input logic [7:0] b);
    int t;
    @(negedge clk);
    if (gaps && ($urandom_range(0, 3) == 0)) begin
      lif.ld_valid = 1'b0;
      lif.ld_byte  = 8'($urandom);
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    lif.ld_byte  = b;
    lif.ld_valid = 1'b1;
    t = 0;
    while (!lif.ld_ready && t < 10) begin
      @(negedge clk);
      t++;
    end
    if (!lif.ld_ready) begin
      checks++; errors++;
      $display("FAIL handshake_timeout: ld_ready=%b required 1", lif.ld_ready);
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    lif.ld_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_pkt();
    foreach (pkt[i]) send_byte(pkt[i]);
  endtask

  // Append checksum (if the build carries one); bad corrupts it.
  task automatic add_csum(input bit bad);
`ifdef PROG_CHECKSUM_EN
    logic [7:0] cs;
    cs = 8'h00;
    foreach (pkt[i]) cs ^= pkt[i];
    if (bad) cs ^= 8'(1 << $urandom_range(0, 7));
    pkt.push_back(cs);
`else
    if (bad) pkt.push_back(8'h00);  // never called with bad=1 in this build
`endif
  endtask

  // Reference packet builder: writes land at (addr + k) mod 2^ADDR_W.
  task automatic build_mem(input bit dm, input logic [15:0] a, input logic [15:0] n, input bit bad);
    logic [31:0] w;
    int ea;
    pkt.delete();
    pkt.push_back(dm ? LD_CMD_DMEM : LD_CMD_IMEM);
    pkt.push_back(a[7:0]);  pkt.push_back(a[15:8]);
    pkt.push_back(n[7:0]);  pkt.push_back(n[15:8]);
    for (int k = 0; k < int'(n); k++) begin
      w  = $urandom;
      ea = (int'(a) + k) % (1 << ADDR_W);
      for (int j = 0; j < 4; j++) pkt.push_back(w[8*j +: 8]);
      if (dm) exp_d.push_back({ADDR_W'(ea), w});
      else    exp_i.push_back({ADDR_W'(ea), w});
    end
    add_csum(bad);
  endtask

  task automatic test_reset();
    lif.ld_valid = 1'b0; lif.ld_byte = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (lif.ld_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", lif.ld_ready); end
    checks++; if ({ld_busy, ld_err, imem_w_en, dmem_w_en, prog_o, core_rst_n} !== 6'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 000000", {ld_busy, ld_err, imem_w_en, dmem_w_en, prog_o, core_rst_n}); end
    checks++; if ({imem_addr, imem_data, dmem_addr, dmem_data} !== '0) begin
      errors++; $display("FAIL reset_bus: got %h want 0", {imem_addr, imem_data, dmem_addr, dmem_data}); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (ld_busy !== 1'b0 || lif.ld_ready !== 1'b1) begin
      errors++; $display("FAIL post_reset_idle: busy=%b ready=%b want 0/1", ld_busy, lif.ld_ready); end
  endtask

  task automatic test_commands();
    send_byte(LD_CMD_RUN); #1;
    checks++; if (core_rst_n !== 1'b1) begin errors++; $display("FAIL run_core_rst: got %b want 1", core_rst_n); end
    send_byte(LD_CMD_HALT); #1;
    checks++; if (core_rst_n !== 1'b0) begin errors++; $display("FAIL halt_core_rst: got %b want 0", core_rst_n); end
    send_byte(LD_CMD_RUN);
    idle(1);
    checks++; if (core_rst_n !== 1'b1) begin errors++; $display("FAIL run2_core_rst: got %b want 1", core_rst_n); end
  endtask

  task automatic test_load_imem();
    got_i.delete(); got_d.delete(); rdy_low = 0;
    pkt = '{8'h01, 8'h10, 8'h00, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    add_csum(1'b0);
    send_pkt();
    idle(3);
    checks++; if (got_i.size() != 2) begin errors++; $display("FAIL imem_count: got %0d want 2", got_i.size()); end
    else begin
      checks++; if (got_i[0] !== {12'h010, 32'h44332211}) begin errors++; $display("FAIL imem_w0: got %h want %h", got_i[0], {12'h010, 32'h44332211}); end
      checks++; if (got_i[1] !== {12'h011, 32'h88776655}) begin errors++; $display("FAIL imem_w1: got %h want %h", got_i[1], {12'h011, 32'h88776655}); end
    end
    checks++; if (got_d.size() != 0) begin errors++; $display("FAIL imem_no_dmem: got %0d want 0", got_d.size()); end
    checks++; if (core_rst_n !== 1'b0) begin errors++; $display("FAIL imem_core_rst: got %b want 0", core_rst_n); end
    checks++; if (rdy_low != 2) begin errors++; $display("FAIL imem_ready_low: got %0d want 2", rdy_low); end
    checks++; if (ld_busy !== 1'b0 || ld_err !== 1'b0) begin errors++; $display("FAIL imem_end: busy=%b err=%b want 0/0", ld_busy, ld_err); end
  endtask

  task automatic test_load_dmem();
    got_i.delete(); got_d.delete(); exp_d.delete(); prog_bad = 0;
    build_mem(1'b1, 16'h0FFF, 16'd2, 1'b0);
    for (int i = 0; i < 5; i++) send_byte(pkt[i]);
    #1;
    checks++; if (prog_o !== 1'b1) begin errors++; $display("FAIL dmem_prog_hdr: got %b want 1", prog_o); end
    for (int i = 5; i < pkt.size(); i++) send_byte(pkt[i]);
    idle(2);
    checks++; if (got_d.size() != 2) begin errors++; $display("FAIL dmem_count: got %0d want 2", got_d.size()); end
    else begin
      checks++; if (got_d[0] !== exp_d[0]) begin errors++; $display("FAIL dmem_w0: got %h want %h", got_d[0], exp_d[0]); end
      checks++; if (got_d[1] !== exp_d[1]) begin errors++; $display("FAIL dmem_w1_wrap: got %h want %h", got_d[1], exp_d[1]); end
    end
    checks++; if (prog_bad != 0) begin errors++; $display("FAIL dmem_prog_at_strobe: got %0d low strobes want 0", prog_bad); end
    checks++; if (prog_o !== 1'b0) begin errors++; $display("FAIL dmem_prog_after: got %b want 0", prog_o); end
    checks++; if (got_i.size() != 0) begin errors++; $display("FAIL dmem_no_imem: got %0d want 0", got_i.size()); end
    exp_d.delete();
  endtask

  task automatic test_unknown();
    logic [7:0] c;
    got_i.delete(); got_d.delete();
    send_byte(8'h7E);
    idle(2);
    checks++; if (ld_err !== 1'b1 || ld_busy !== 1'b0) begin errors++; $display("FAIL unk_err: err=%b busy=%b want 1/0", ld_err, ld_busy); end
    send_byte(LD_CMD_CLR);
    idle(1);
    checks++; if (ld_err !== 1'b0) begin errors++; $display("FAIL clr_err: got %b want 0", ld_err); end
    c = 8'($urandom_range(5, 255));
    send_byte(c);
    idle(1);
    checks++; if (ld_err !== 1'b1) begin errors++; $display("FAIL unk_rand %h: got %b want 1", c, ld_err); end
    checks++; if (got_i.size() + got_d.size() != 0) begin errors++; $display("FAIL unk_no_strobe: got %0d want 0", got_i.size() + got_d.size()); end
    send_byte(LD_CMD_CLR);
    idle(1);
  endtask

  task automatic test_checksum();
`ifdef PROG_CHECKSUM_EN
    got_i.delete(); exp_i.delete();
    build_mem(1'b0, 16'h0020, 16'd1, 1'b0);
    send_pkt(); idle(2);
    checks++; if (ld_err !== 1'b0) begin errors++; $display("FAIL csum_good_err: got %b want 0", ld_err); end
    pkt[pkt.size()-1] ^= 8'h5A;
    exp_i.push_back(exp_i[0]);
    send_pkt(); idle(2);
    checks++; if (ld_err !== 1'b1) begin errors++; $display("FAIL csum_bad_err: got %b want 1", ld_err); end
    checks++; if (got_i.size() != 2) begin errors++; $display("FAIL csum_writes: got %0d want 2", got_i.size()); end
    else begin
      checks++; if (got_i[1] !== exp_i[1]) begin errors++; $display("FAIL csum_bad_write: got %h want %h", got_i[1], exp_i[1]); end
    end
    exp_i.delete();
    send_byte(LD_CMD_CLR); idle(1);
`endif
  endtask

  task automatic test_reset_mid();
    got_i.delete(); got_d.delete(); exp_i.delete();
    pkt = '{8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'hAA, 8'hBB};
    send_pkt();
    #1;
    lif.ld_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if ({ld_busy, ld_err, imem_w_en, dmem_w_en, prog_o, core_rst_n, lif.ld_ready} !== 7'b0000001) begin
      errors++; $display("FAIL midrst_flags: got %b want 0000001", {ld_busy, ld_err, imem_w_en, dmem_w_en, prog_o, core_rst_n, lif.ld_ready}); end
    checks++; if ({imem_addr, imem_data, dmem_addr, dmem_data} !== '0) begin
      errors++; $display("FAIL midrst_bus: got %h want 0", {imem_addr, imem_data, dmem_addr, dmem_data}); end
    @(negedge clk); rst_n = 1'b1;
    idle(3);
    checks++; if (got_i.size() != 0) begin errors++; $display("FAIL midrst_no_write: got %0d want 0", got_i.size()); end
    build_mem(1'b0, 16'h0005, 16'd1, 1'b0);
    send_pkt(); idle(2);
    checks++; if (got_i.size() != 1 || got_i[0] !== exp_i[0]) begin
      errors++; $display("FAIL midrst_fresh_word: n=%0d got %h want %h", got_i.size(), (got_i.size() > 0) ? got_i[0] : '0, exp_i[0]); end
    exp_i.delete();
  endtask

  task automatic test_random();
    bit exp_core = 1'b0;
    bit exp_err  = 1'b0;
    bit dm, bad;
    logic [15:0] a, n;
    int r;
    got_i.delete(); got_d.delete(); exp_i.delete(); exp_d.delete(); prog_bad = 0;
    gaps = 1'b1;
    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 3);
      if (r < 2) begin
        dm = 1'($urandom);
        a  = 16'($urandom);
        if ($urandom_range(0, 3) == 0) a[ADDR_W-1:0] = {ADDR_W{1'b1}};  // exercise wrap
        n  = 16'($urandom_range(0, 3));
`ifdef PROG_CHECKSUM_EN
        bad = ($urandom_range(0, 3) == 0);
`else
        bad = 1'b0;
`endif
        build_mem(dm, a, n, bad);
        send_pkt(); idle(2);
        exp_core = 1'b0;
        if (bad) exp_err = 1'b1;
        checks++; if (ld_busy !== 1'b0 || prog_o !== 1'b0) begin
          errors++; $display("FAIL rnd_pkt_end %0d: busy=%b prog=%b want 0/0", it, ld_busy, prog_o); end
      end else if (r == 2) begin
        exp_core = 1'($urandom);
        send_byte(exp_core ? LD_CMD_RUN : LD_CMD_HALT); idle(1);
      end else begin
        if ($urandom_range(0, 1) == 0) begin send_byte(LD_CMD_CLR); exp_err = 1'b0; end
        else begin send_byte(8'($urandom_range(5, 255))); exp_err = 1'b1; end
        idle(1);
      end
      checks++; if (core_rst_n !== exp_core || ld_err !== exp_err) begin
        errors++; $display("FAIL rnd_state %0d: core=%b err=%b want %b/%b", it, core_rst_n, ld_err, exp_core, exp_err); end
    end
    gaps = 1'b0;
    checks++; if (got_i.size() != exp_i.size() || got_d.size() != exp_d.size()) begin
      errors++; $display("FAIL rnd_counts: imem %0d/%0d dmem %0d/%0d (got/want)", got_i.size(), exp_i.size(), got_d.size(), exp_d.size());
    end else begin
      foreach (exp_i[i]) begin
        checks++; if (got_i[i] !== exp_i[i]) begin errors++; $display("FAIL rnd_imem[%0d]: got %h want %h", i, got_i[i], exp_i[i]); end
      end
      foreach (exp_d[i]) begin
        checks++; if (got_d[i] !== exp_d[i]) begin errors++; $display("FAIL rnd_dmem[%0d]: got %h want %h", i, got_d[i], exp_d[i]); end
      end
    end
    checks++; if (prog_bad != 0) begin errors++; $display("FAIL rnd_prog_at_strobe: got %0d want 0", prog_bad); end
  endtask

  initial begin
    test_reset();
    test_commands();
    test_load_imem();
    test_load_dmem();
    test_unknown();
    test_checksum();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32_prog_loader.md
# rv32_prog_loader

Byte-stream program loader upstream of `rv32_core`. It accepts framed command packets over a valid/ready byte interface, assembles little-endian 32-bit words, and drives the core's instruction- and data-memory programming ports. It also holds the core in reset while images are loaded and releases it on command.

## Interface
Parameters:
- `ADDR_W`, default 12: word-address width of imem/dmem write ports.

Ports:
- `rv32_io_clk`  in  1  clock.
- `rv32_io_rst_n`  in  1  reset; asynchronous, active-low.
- `ld_byte`  in  8  incoming stream byte.
- `ld_valid`  in  1  `ld_byte` valid.
- `ld_ready`  out  1  loader can accept a byte this cycle.
- `rv32_io_imem_addr`  out  ADDR_W  imem word write address.
- `rv32_io_imem_data`  out  32  imem write word.
- `rv32_io_imem_w_en`  out  1  imem write strobe, 1-cycle pulse.
- `rv32_io_dmem_addr`  out  ADDR_W  dmem word write address.
- `rv32_io_dmem_data`  out  32  dmem write word.
- `rv32_io_dmem_w_en`  out  1  dmem write strobe, 1-cycle pulse.
- `rv32_io_program`  out  1  steers core dmem write mux to io ports.
- `core_rst_n`  out  1  core reset; 0 holds core.
- `ld_busy`  out  1  packet in progress (state ≠ IDLE).
- `ld_err`  out  1  sticky error flag.

## Operation
- Byte transfer occurs on a cycle with `ld_valid & ld_ready`.
- Packet framing:
  - byte 0 is CMD.
  - IMEM (0x01) and DMEM (0x02) packets continue with ADDR[7:0], ADDR[15:8], CNT[7:0], CNT[15:8], then CNT×4 data bytes, LSB first per word.
  - RUN (0x03), HALT (0x04) and CLR (0x00) are single-byte packets.
- Command effects:
  - RUN: `core_rst_n` ← 1.
  - HALT: `core_rst_n` ← 0.
  - CLR: `ld_err` ← 0.
  - IMEM/DMEM: `core_rst_n` ← 0 on header acceptance.
  - Any other CMD: `ld_err` ← 1; state stays IDLE.
- ADDR bits above `ADDR_W` are ignored.
- States:
  - IDLE → ADDR0 → ADDR1 → CNT0 → CNT1.
  - CNT1 → DATA if CNT≠0; otherwise → CSUM (when enabled) or IDLE.
  - DATA collects 4 bytes, then → WRITE.
  - WRITE issues 1 strobe and increments the address and word counter.
  - WRITE → DATA if words remain; otherwise → CSUM or IDLE.
- Address wraps modulo 2^`ADDR_W`. CNT = 0xFFFF is legal and wraps the address.
- `rv32_io_program` is 1 from DMEM header acceptance until the cycle after the last DMEM write (or CNT1 when CNT=0); otherwise 0.
- `_data`/`_addr` outputs hold their last written value between strobes.

## Timing
- Reset values:
  - `ld_ready` = 1, `ld_busy` = 0, `ld_err` = 0.
  - all `_w_en` = 0, `rv32_io_program` = 0, `core_rst_n` = 0.
  - addr/data outputs = 0; state = IDLE.
- `ld_ready` is 0 only in WRITE, for exactly 1 cycle per word.
- Streaming throughput: 4 bytes per 5 cycles.
- Strobe timing: the strobe is asserted in the cycle after the 4th data byte is accepted, with address and data registered and valid in that same cycle.
- Address increment is visible one cycle after the strobe.
- `core_rst_n` changes 1 cycle after the command byte is accepted.
- Reset mid-packet returns to IDLE immediately. A partially assembled word is discarded, and no strobe is issued for it.
- `ld_valid` low in any state stalls without side effects.

## Configuration
- Macro: `PROG_CHECKSUM_EN`.
- Defined:
  - IMEM/DMEM packets carry one trailing checksum byte, accepted in state CSUM.
  - The XOR of all packet bytes including the checksum must be 0x00. On mismatch, `ld_err` ← 1.
  - Writes already performed are not undone.
  - Single-byte commands carry no checksum.
- Undefined: no CSUM state, and `ld_err` is set only by an unknown CMD.

## Structure
- Shared package `rv32_pkg`:
  - command code constants `LD_CMD_*`;
  - loader state enum `rv32_ld_state_t`;
  - reuse of the existing `rv_imem_addr_t`/`rv32_data_t` types where widths match.
- One sub-module, `rv32_word_assembler`: byte shift register plus 2-bit byte counter; outputs a word and a `word_done` pulse; clears on state IDLE.
- Top: FSM, address/count registers, strobe generation, checksum accumulator.

## Test plan
- Load imem:
  - Stimulus: 01 10 00 02 00, then bytes 11 22 33 44 55 66 77 88.
  - Required response: imem writes 0x44332211 @0x010 and 0x88776655 @0x011; one `w_en` pulse each; `core_rst_n` = 0.
- Load dmem:
  - Stimulus: 02 FF 0F 02 00 with 2 words.
  - Required response: writes @0xFFF then @0x000 (wrap); `rv32_io_program` high throughout, low afterwards.
- Command sequence:
  - Stimulus: RUN (03), then HALT (04).
  - Required response: `core_rst_n` 0→1 one cycle after 03, 1→0 one cycle after 04.
- Unknown command:
  - Stimulus: CMD 0x7E.
  - Required response: `ld_err` = 1, no strobes; 00 clears `ld_err`.
- Reset mid-packet:
  - Stimulus: assert reset after 2 data bytes.
  - Required response: no write, state IDLE, all outputs at reset values.
- Checksum (`PROG_CHECKSUM_EN`):
  - Stimulus: 1-word IMEM packet with correct checksum, then the same packet with a corrupted checksum.
  - Required response: `ld_err` stays 0 for the correct checksum and becomes 1 for the corrupted one; the write occurs in both cases.
